inst_loader: RTL and testbench
==============================

# inst_loader

Program loader that sits directly upstream of the instruction-fetch stage and fills its instruction memory before execution starts. It takes a byte stream from the debug UART receiver, assembles big-endian 32-bit instruction words, and emits one-cycle write strobes with word and byte address. Loading ends on a HALT word, memory full, or abort. It drives the fetch stage's write-data/write-strobe inputs while the pipeline enable is low.

## Interface
- INST_SZ, 32, instruction width in bits; a whole number of bytes.
- MEM_WORDS, 256, instruction-memory capacity in words.
- ADDR_SZ, 32, width of the byte address output.
- HALT_INST, 32'hFFFF_FFFF, word that terminates loading.

- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  arm loader; pulse, sampled in IDLE/DONE.
- i_enable  in  1  pipeline execution enable; must be low while loading.
- i_rx_valid  in  1  one-cycle strobe: i_rx_data is valid.
- i_rx_data  in  8  received byte.
- o_instruction  out  INST_SZ  assembled word for instruction memory.
- o_addr  out  ADDR_SZ  byte address of o_instruction (word index × 4).
- o_write  out  1  one-cycle write strobe to instruction memory.
- o_count  out  clog2(MEM_WORDS)+1  words written since last start.
- o_busy  out  1  high in LOAD.
- o_done  out  1  high in DONE.
- o_overflow  out  1  sticky: memory filled without HALT.
- o_abort  out  1  sticky: i_enable rose during LOAD.

## Operation
- States: IDLE, LOAD, DONE.
  - IDLE: i_start → LOAD; clears count, byte index, overflow and abort.
  - LOAD: each i_rx_valid shifts i_rx_data into the word shift register, MSB first, and increments byte index 0..3.
  - DONE: i_start → LOAD (reload; memory is overwritten from address 0).
- Fourth byte accepted:
  - register word → o_instruction;
  - o_addr = count × 4;
  - o_write = 1 for one cycle;
  - count += 1;
  - byte index wraps to 0.
- Word == HALT_INST: it is written like any other word, then → DONE on the same edge.
- count reaches MEM_WORDS after a non-HALT word: → DONE, o_overflow = 1. Bytes arriving afterwards are ignored.
- i_enable = 1 while in LOAD: → IDLE, o_abort = 1, partial word discarded, no write.
- i_rx_valid in IDLE or DONE: ignored.
- i_start in LOAD: ignored.
- Reset values:
  - state IDLE;
  - o_instruction, o_addr, o_count = 0;
  - o_write, o_busy, o_done, o_overflow, o_abort = 0;
  - byte index 0.
- Reset mid-load: everything returns to reset values; a partial word is never written.

## Timing
- o_write is registered and asserts in the cycle after the edge that accepted byte 3. o_instruction and o_addr are stable during that cycle.
- Back-to-back bytes (i_rx_valid every cycle) are accepted. The write strobe of word n overlaps acceptance of the bytes of word n+1 with no stall.
- o_done and o_write for the HALT word assert in the same cycle.
- o_busy is low in the cycle o_done rises.
- The abort check takes priority over byte acceptance on the same edge.
- i_start in IDLE: o_busy is high from the next cycle.

## Structure
- A shared package holds the state enum (IDLE/LOAD/DONE), the HALT_INST default, and the byte-per-word constant (INST_SZ/8).
- Natural sub-module: byte_assembler (shift register plus byte index; outputs word and word_valid pulse). The loader FSM, address/count logic and flags stay in inst_loader.

## Test plan
- Reset, start, bytes 0x20,0x08,0x00,0x05 → o_write pulse with o_instruction = 32'h2008_0005, o_addr = 0, o_count = 1.
- Three words then FF,FF,FF,FF, sent back-to-back → four writes at addresses 0, 4, 8, 12; o_done in the same cycle as the fourth write; o_count = 4.
- MEM_WORDS = 4, five non-HALT words → four writes, o_overflow = 1, DONE, no write for the fifth word.
- Two bytes sent, then i_enable = 1 → no write, o_abort = 1, IDLE.
- i_reset asserted after byte 2 of a word → all outputs 0. A new start plus four bytes writes at address 0.
- Bytes sent in IDLE, then start and 0x00,0x00,0x00,0x01 → single write of 32'h0000_0001 at address 0; the earlier bytes are not merged into it.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Shared constants for the program loader: FSM state codes, default HALT word
// and the number of bytes that make up one instruction word.
package inst_loader_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam int          INST_SZ_DEFAULT   = 32;
  localparam int          BYTES_PER_WORD    = INST_SZ_DEFAULT / 8;
  localparam logic [31:0] HALT_INST_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/inst_loader_byte_assembler.sv
// Collects received bytes MSB first into one instruction word; flags the
// byte that completes a word combinationally so the loader can register it.
module inst_loader_byte_assembler
  import inst_loader_pkg::*;
#(
  parameter int NBYTES = BYTES_PER_WORD
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_data,
  output logic [8*NBYTES-1:0]   o_word,
  output logic                  o_word_valid
);

  localparam int SW = 8 * (NBYTES - 1);
  localparam int IW = (NBYTES > 2) ? $clog2(NBYTES) : 1;

  logic [SW-1:0] shift_q, shift_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          last_byte;

  assign last_byte    = (idx_q == IW'(NBYTES - 1));
  assign o_word       = {shift_q, i_rx_data};
  assign o_word_valid = i_rx_valid && !i_clear && last_byte;

  // Clearing only the index is enough: stale bytes are shifted out before
  // the next word completes.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (i_clear) begin
      idx_d = '0;
    end else if (i_rx_valid) begin
      shift_d = SW'({shift_q, i_rx_data});
      idx_d   = last_byte ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Program loader: turns the debug UART byte stream into instruction-memory
// write strobes until a HALT word, memory full, or an abort.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for i_start; rx bytes ignored
// LOAD    | assembling words and writing them to instruction memory
// DONE    | load finished (HALT or full); i_start reloads from address 0
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int                 INST_SZ   = INST_SZ_DEFAULT,
  parameter int                 MEM_WORDS = 256,
  parameter int                 ADDR_SZ   = 32,
  parameter logic [INST_SZ-1:0] HALT_INST = INST_SZ'(HALT_INST_DEFAULT),
  localparam int                CW        = $clog2(MEM_WORDS) + 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_enable,
  input  logic               i_rx_valid,
  input  logic [7:0]         i_rx_data,
  output logic [INST_SZ-1:0] o_instruction,
  output logic [ADDR_SZ-1:0] o_addr,
  output logic               o_write,
  output logic [CW-1:0]      o_count,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overflow,
  output logic               o_abort
);

  state_t             state_q, state_d;
  logic [INST_SZ-1:0] instr_q, instr_d;
  logic [ADDR_SZ-1:0] addr_q, addr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               write_q, write_d;
  logic               overflow_q, overflow_d;
  logic               abort_q, abort_d;

  logic               asm_clear;
  logic [INST_SZ-1:0] asm_word;
  logic               asm_word_valid;

  // Outside LOAD, or on an abort, any partial word is thrown away.
  assign asm_clear = (state_q != ST_LOAD) || i_enable;

  inst_loader_byte_assembler #(
    .NBYTES (INST_SZ / 8)
  ) u_byte_assembler (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (asm_clear),
    .i_rx_valid   (i_rx_valid),
    .i_rx_data    (i_rx_data),
    .o_word       (asm_word),
    .o_word_valid (asm_word_valid)
  );

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    addr_d     = addr_q;
    count_d    = count_q;
    write_d    = 1'b0;
    overflow_d = overflow_q;
    abort_d    = abort_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d    = ST_LOAD;
          count_d    = '0;
          overflow_d = 1'b0;
          abort_d    = 1'b0;
        end
      end
      ST_LOAD: begin
        if (i_enable) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else if (asm_word_valid) begin
          instr_d = asm_word;
          addr_d  = ADDR_SZ'(count_q) << 2;
          write_d = 1'b1;
          count_d = count_q + CW'(1);
          // HALT is checked first so a HALT in the last slot is not an overflow.
          if (asm_word == HALT_INST) begin
            state_d = ST_DONE;
          end else if (count_q == CW'(MEM_WORDS - 1)) begin
            state_d    = ST_DONE;
            overflow_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      write_q    <= 1'b0;
      overflow_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      write_q    <= write_d;
      overflow_q <= overflow_d;
      abort_q    <= abort_d;
    end
  end

  assign o_instruction = instr_q;
  assign o_addr        = addr_q;
  assign o_write       = write_q;
  assign o_count       = count_q;
  assign o_busy        = (state_q == ST_LOAD);
  assign o_done        = (state_q == ST_DONE);
  assign o_overflow    = overflow_q;
  assign o_abort       = abort_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed plus randomized bench for inst_loader with a 4-word memory; writes
// are scoreboarded against a byte-list model of the loader's rules.
module tb_inst_loader;

  localparam int          MEM_WORDS = 4;
  localparam logic [31:0] HALT      = 32'hFFFF_FFFF;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        done;
    logic        busy;
  } wr_t;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic        i_enable = 1'b0;
  logic        i_rx_valid = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic [31:0] o_instruction;
  logic [31:0] o_addr;
  logic        o_write;
  logic [2:0]  o_count;
  logic        o_busy;
  logic        o_done;
  logic        o_overflow;
  logic        o_abort;

  int vectors = 0;
  int miscompares = 0;

  wr_t         obs[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_done;
  logic        exp_ovf;
  bq_t         bq;

  inst_loader #(
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_enable      (i_enable),
    .i_rx_valid    (i_rx_valid),
    .i_rx_data     (i_rx_data),
    .o_instruction (o_instruction),
    .o_addr        (o_addr),
    .o_write       (o_write),
    .o_count       (o_count),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_overflow    (o_overflow),
    .o_abort       (o_abort)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_write === 1'b1) obs.push_back('{o_addr, o_instruction, o_done, o_busy});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    assert (got === want)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    repeat (2) step();
    i_reset = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    step();
    i_rx_valid = 1'b0;
    i_rx_data  = $urandom_range(255, 0);
    repeat (gap) step();
  endtask

  function automatic void add_word(input logic [31:0] w);
    bq.push_back(w[31:24]);
    bq.push_back(w[23:16]);
    bq.push_back(w[15:8]);
    bq.push_back(w[7:0]);
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  // Reference: group bytes into big-endian words; stop after HALT or when full.
  function automatic void build_expect(input bq_t b);
    logic [31:0] w;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 1'b0;
    exp_ovf  = 1'b0;
    for (int i = 0; i + 3 < b.size(); i += 4) begin
      w = {b[i], b[i+1], b[i+2], b[i+3]};
      exp_addr.push_back(32'(exp_data.size() * 4));
      exp_data.push_back(w);
      if (w == HALT) begin
        exp_done = 1'b1;
        break;
      end
      if (exp_data.size() == MEM_WORDS) begin
        exp_done = 1'b1;
        exp_ovf  = 1'b1;
        break;
      end
    end
  endfunction

  task automatic run_load(input bq_t b, input int max_gap);
    obs.delete();
    build_expect(b);
    pulse_start();
    foreach (b[i]) send_byte(b[i], $urandom_range(max_gap, 0));
    repeat (3) step();
  endtask

  task automatic check_load(input string tag);
    int n;
    chk({tag, ".nwrites"}, 64'(obs.size()), 64'(exp_data.size()));
    n = (obs.size() < exp_data.size()) ? obs.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, ".addr"}, 64'(obs[i].addr), 64'(exp_addr[i]));
      chk({tag, ".data"}, 64'(obs[i].data), 64'(exp_data[i]));
      chk({tag, ".done_at_write"}, 64'(obs[i].done), 64'(exp_done && (i == exp_data.size() - 1)));
      if (exp_done && (i == exp_data.size() - 1))
        chk({tag, ".busy_at_last"}, 64'(obs[i].busy), 64'(0));
    end
    chk({tag, ".count"}, 64'(o_count), 64'(exp_data.size()));
    chk({tag, ".done"}, 64'(o_done), 64'(exp_done));
    chk({tag, ".busy"}, 64'(o_busy), 64'(!exp_done));
    chk({tag, ".overflow"}, 64'(o_overflow), 64'(exp_ovf));
    chk({tag, ".abort"}, 64'(o_abort), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".instr"}, 64'(o_instruction), 64'(0));
    chk({tag, ".addr"}, 64'(o_addr), 64'(0));
    chk({tag, ".count"}, 64'(o_count), 64'(0));
    chk({tag, ".flags"}, 64'({o_write, o_busy, o_done, o_overflow, o_abort}), 64'(0));
  endtask

  initial begin
    int k;
    logic [31:0] w;

    // Reset state and a single word with write-strobe timing.
    do_reset();
    check_all_zero("reset");
    obs.delete();
    pulse_start();
    chk("start.busy", 64'(o_busy), 64'(1));
    send_byte(8'h20, 0);
    i_start = 1'b1;
    send_byte(8'h08, 1);
    i_start = 1'b0;
    send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    chk("w1.write", 64'(o_write), 64'(1));
    chk("w1.instr", 64'(o_instruction), 64'h2008_0005);
    chk("w1.addr", 64'(o_addr), 64'(0));
    chk("w1.count", 64'(o_count), 64'(1));
    step();
    chk("w1.write_one_cycle", 64'(o_write), 64'(0));

    // Back-to-back: three words then HALT.
    do_reset();
    bq.delete();
    for (int i = 0; i < 3; i++) add_word(rand_word());
    add_word(HALT);
    run_load(bq, 0);
    check_load("halt_b2b");

    // Five words into a four-word memory.
    do_reset();
    bq.delete();
    for (int i = 0; i < 5; i++) add_word(rand_word());
    run_load(bq, 1);
    check_load("overflow");

    // Randomized reloads from DONE; every load ends by HALT or overflow.
    for (int it = 0; it < 15; it++) begin
      bq.delete();
      k = $urandom_range(5, 1);
      for (int i = 0; i < k; i++) add_word(rand_word());
      if (k < MEM_WORDS || $urandom_range(1, 0) == 1) add_word(HALT);
      for (int i = 0; i < int'($urandom_range(5, 0)); i++) bq.push_back(8'($urandom));
      run_load(bq, 2);
      check_load("random");
    end

    // Abort after two bytes; later idle bytes must not leak into the next load.
    obs.delete();
    pulse_start();
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    i_enable = 1'b1;
    i_rx_valid = 1'b1;
    i_rx_data = 8'h56;
    step();
    i_enable = 1'b0;
    i_rx_valid = 1'b0;
    repeat (2) step();
    chk("abort.flag", 64'(o_abort), 64'(1));
    chk("abort.busy", 64'(o_busy), 64'(0));
    chk("abort.done", 64'(o_done), 64'(0));
    chk("abort.nwrites", 64'(obs.size()), 64'(0));
    chk("abort.count", 64'(o_count), 64'(0));
    send_byte(8'h9A, 0);
    send_byte(8'hBC, 0);
    chk("abort.idle_bytes", 64'(obs.size()), 64'(0));
    bq.delete();
    add_word(rand_word());
    add_word(HALT);
    run_load(bq, 1);
    check_load("after_abort");

    // Reset in the middle of a word.
    obs.delete();
    pulse_start();
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    do_reset();
    check_all_zero("midreset");
    chk("midreset.nwrites", 64'(obs.size()), 64'(0));
    bq.delete();
    w = rand_word();
    add_word(w);
    run_load(bq, 1);
    check_load("after_reset");

    // Bytes in IDLE are ignored.
    do_reset();
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 1);
    send_byte(8'hCC, 0);
    bq.delete();
    add_word(32'h0000_0001);
    run_load(bq, 0);
    check_load("idle_bytes");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
